asic_multichannel_function_interface: RTL and testbench

Parametrised sequencer for driving an analog ASIC function and reading its response. Per request it:
- writes a DAC code to one of NUM_CH DAC channels through the PMOD DAC serializer handshake,
- waits a programmable settling time,
- collects 2^AVG_LOG2 ADC conversions from the matching ADC DRP address and returns the averaged result with a channel tag.

It sits between the SoC register/stream logic and the PMOD DAC and XADC wrappers. A watchdog aborts stalled transactions.

---
 rtl/asic_multichannel_function_interface_if.sv | 40 ++++
 rtl/asic_multichannel_function_interface.sv | 180 ++++++++++++++++++
 tb/tb_asic_multichannel_function_interface.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/asic_multichannel_function_interface_if.sv
// Bundle between the SoC request side, the PMOD DAC serializer and the XADC DRP port.
// slave is the sequencer's view; master is the surrounding SoC/peripheral side.
interface asic_multichannel_function_interface_if #(
  parameter int DAC_W    = 16,
  parameter int ADC_W    = 12,
  parameter int CH_W     = 2,
  parameter int SETTLE_W = 16
);
  logic                start;
  logic [CH_W-1:0]     ch_sel;
  logic [DAC_W-1:0]    data_in;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                busy;
  logic                result_valid;
  logic [ADC_W-1:0]    result;
  logic [CH_W-1:0]     result_ch;
  logic                err_timeout;
  logic                dac_start;
  logic [DAC_W-1:0]    dac_data;
  logic [CH_W-1:0]     dac_ch;
  logic                dac_busy;
  logic                adc_eoc;
  logic                adc_den;
  logic [6:0]          adc_daddr;
  logic                adc_drdy;
  logic [15:0]         adc_do;
  logic [2:0]          state_out;

  modport slave (
    input  start, ch_sel, data_in, settle_cycles, dac_busy, adc_eoc, adc_drdy, adc_do,
    output busy, result_valid, result, result_ch, err_timeout, dac_start, dac_data,
           dac_ch, adc_den, adc_daddr, state_out
  );

  modport master (
    output start, ch_sel, data_in, settle_cycles, dac_busy, adc_eoc, adc_drdy, adc_do,
    input  busy, result_valid, result, result_ch, err_timeout, dac_start, dac_data,
           dac_ch, adc_den, adc_daddr, state_out
  );
endinterface

// File: rtl/asic_multichannel_function_interface.sv
// Request sequencer: DAC write, settle, averaged ADC read-back with channel tag.
// A single watchdog counter guards every state that waits on a peripheral.
module asic_multichannel_function_interface #(
  parameter int         DAC_W     = 16,
  parameter int         ADC_W     = 12,
  parameter int         NUM_CH    = 4,
  parameter int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int         AVG_LOG2  = 2,
  parameter logic [6:0] ADDR_BASE = 7'h10,
  parameter int         SETTLE_W  = 16,
  parameter int         TIMEOUT   = 65535
) (
  input  logic clk,
  input  logic rst,
  asic_multichannel_function_interface_if.slave bus
);
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DAC_LOAD  = 3'd1,
    DAC_WAIT  = 3'd2,
    SETTLE    = 3'd3,
    WAIT_EOC  = 3'd4,
    READ_REQ  = 3'd5,
    READ_WAIT = 3'd6,
    DONE      = 3'd7
  } state_t;

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic [DAC_W-1:0]    code;
    logic [SETTLE_W-1:0] settle;
  } req_t;

  state_t              state;
  req_t                req;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [WD_W-1:0]     wd_cnt;
  logic [ACC_W-1:0]    acc;
  logic [SMP_W-1:0]    smp_cnt;
  logic                busy, result_valid, err_timeout, dac_start, adc_den;
  logic [ADC_W-1:0]    result;
  logic [CH_W-1:0]     result_ch;
  logic [6:0]          adc_daddr;

  logic [ADC_W-1:0] sample;
  logic [ACC_W-1:0] acc_sum;
  logic [SMP_W-1:0] smp_nxt;
  logic             wd_hit;

  assign sample  = bus.adc_do[15 -: ADC_W];
  assign acc_sum = acc + ACC_W'(sample);
  assign smp_nxt = smp_cnt + SMP_W'(1);
  assign wd_hit  = (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req          <= '0;
      settle_cnt   <= '0;
      wd_cnt       <= '0;
      acc          <= '0;
      smp_cnt      <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      result_ch    <= '0;
      err_timeout  <= 1'b0;
      dac_start    <= 1'b0;
      adc_den      <= 1'b0;
      adc_daddr    <= '0;
    end else begin
      dac_start    <= 1'b0;
      adc_den      <= 1'b0;
      result_valid <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (bus.start) begin
            req        <= '{ch: bus.ch_sel, code: bus.data_in, settle: bus.settle_cycles};
            adc_daddr  <= ADDR_BASE + 7'(bus.ch_sel);
            acc        <= '0;
            smp_cnt    <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
            dac_start  <= 1'b1;
            state      <= DAC_LOAD;
          end
        end
        DAC_LOAD: begin
          wd_cnt <= '0;
          state  <= DAC_WAIT;
        end
        DAC_WAIT: begin
          // wd_cnt==0 marks the first cycle, where dac_busy may not be up yet
          if (wd_cnt != '0 && !bus.dac_busy) begin
            wd_cnt     <= '0;
            settle_cnt <= '0;
            state      <= SETTLE;
          end else if (wd_hit) begin
            wd_cnt      <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        SETTLE: begin
          wd_cnt <= '0;
          if (settle_cnt == req.settle) state <= WAIT_EOC;
          else settle_cnt <= settle_cnt + SETTLE_W'(1);
        end
        WAIT_EOC: begin
          if (bus.adc_eoc) begin
            wd_cnt  <= '0;
            adc_den <= 1'b1;
            state   <= READ_REQ;
          end else if (wd_hit) begin
            wd_cnt      <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        READ_REQ: begin
          wd_cnt <= '0;
          state  <= READ_WAIT;
        end
        READ_WAIT: begin
          // drdy is tested first so a sample landing on the expiry cycle is kept
          if (bus.adc_drdy) begin
            wd_cnt  <= '0;
            acc     <= acc_sum;
            smp_cnt <= smp_nxt;
            if (smp_nxt[AVG_LOG2]) begin
              result       <= acc_sum[ACC_W-1:AVG_LOG2];
              result_ch    <= req.ch;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              state <= WAIT_EOC;
            end
          end else if (wd_hit) begin
            wd_cnt      <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        DONE: begin
          wd_cnt <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy;
  assign bus.result_valid = result_valid;
  assign bus.result       = result;
  assign bus.result_ch    = result_ch;
  assign bus.err_timeout  = err_timeout;
  assign bus.dac_start    = dac_start;
  assign bus.dac_data     = req.code;
  assign bus.dac_ch       = req.ch;
  assign bus.adc_den      = adc_den;
  assign bus.adc_daddr    = adc_daddr;
  assign bus.state_out    = state;
endmodule

// File: tb/tb_asic_multichannel_function_interface.sv
// Bench: two sequencers (single-sample and 4-sample averaging) against behavioural DAC/XADC models.
module tb_asic_multichannel_function_interface;
  localparam int TO = 100;

  typedef struct packed {
    logic [1:0]  ch;
    logic [11:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  asic_multichannel_function_interface_if #(.DAC_W(16), .ADC_W(12), .CH_W(2), .SETTLE_W(16)) ifs[2] ();

  int          busy_len[2];
  bit          eoc_on[2];
  bit          hold_drdy[2];
  bit          pend[2];
  int          bcnt[2];
  logic [15:0] adc_q[2][$];
  exp_t        sb[2][$];
  int          rv_cnt[2], err_cnt[2], den_cnt[2], ds_cnt[2], rv_cyc[2];
  logic [15:0] last_dac_data[2];
  logic [1:0]  last_dac_ch[2];
  logic [6:0]  last_daddr[2];

  for (genvar g = 0; g < 2; g++) begin : lane
    asic_multichannel_function_interface #(
      .DAC_W(16), .ADC_W(12), .NUM_CH(4), .CH_W(2), .AVG_LOG2(g == 0 ? 0 : 2),
      .ADDR_BASE(7'h10), .SETTLE_W(16), .TIMEOUT(TO)
    ) dut (.clk(clk), .rst(rst), .bus(ifs[g]));

    // peripheral model: dac_busy after dac_start, drdy one cycle after den
    always @(negedge clk) begin
      if (rst) begin
        pend[g] = 1'b0;
        bcnt[g] = 0;
        ifs[g].dac_busy = 1'b0;
        ifs[g].adc_drdy = 1'b0;
        ifs[g].adc_eoc  = 1'b0;
        ifs[g].adc_do   = 16'h0;
      end else begin
        ifs[g].adc_eoc  = eoc_on[g];
        ifs[g].adc_drdy = 1'b0;
        if (pend[g] && !hold_drdy[g]) begin
          ifs[g].adc_drdy = 1'b1;
          if (adc_q[g].size() != 0) ifs[g].adc_do = adc_q[g].pop_front();
          else ifs[g].adc_do = 16'h0;
          pend[g] = 1'b0;
        end
        if (ifs[g].adc_den) pend[g] = 1'b1;
        if (bcnt[g] > 0) bcnt[g]--;
        if (ifs[g].dac_start) bcnt[g] = busy_len[g];
        ifs[g].dac_busy = (bcnt[g] > 0);
      end
    end

    always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
        if (ifs[g].result_valid) begin
          rv_cnt[g]++;
          rv_cyc[g] = cyc;
          checks++;
          if (sb[g].size() == 0) begin
            fails++;
            $display("FAIL sb%0d_unexpected got ch=%0d res=%h required no result", g,
                     ifs[g].result_ch, ifs[g].result);
          end else begin
            e = sb[g].pop_front();
            if ({ifs[g].result_ch, ifs[g].result} !== e) begin
              fails++;
              $display("FAIL sb%0d_result got ch=%0d res=%h required ch=%0d res=%h", g,
                       ifs[g].result_ch, ifs[g].result, e.ch, e.val);
            end
          end
        end
        if (ifs[g].err_timeout) err_cnt[g]++;
        if (ifs[g].adc_den) begin
          den_cnt[g]++;
          last_daddr[g] = ifs[g].adc_daddr;
        end
        if (ifs[g].dac_start) begin
          ds_cnt[g]++;
          last_dac_data[g] = ifs[g].dac_data;
          last_dac_ch[g]   = ifs[g].dac_ch;
        end
      end
    end
  end

  task automatic go0(input logic [1:0] ch, input logic [15:0] code, input logic [15:0] st,
                     output int t0);
    @(negedge clk);
    ifs[0].start = 1'b1; ifs[0].ch_sel = ch; ifs[0].data_in = code; ifs[0].settle_cycles = st;
    t0 = cyc;
    @(negedge clk);
    ifs[0].start = 1'b0;
  endtask

  task automatic go2(input logic [1:0] ch, input logic [15:0] code, input logic [15:0] st,
                     output int t0);
    @(negedge clk);
    ifs[1].start = 1'b1; ifs[1].ch_sel = ch; ifs[1].data_in = code; ifs[1].settle_cycles = st;
    t0 = cyc;
    @(negedge clk);
    ifs[1].start = 1'b0;
  endtask

  task automatic test_reset;
    logic [46:0] obs;
    repeat (3) @(negedge clk);
    obs = {ifs[0].busy, ifs[0].result_valid, ifs[0].result, ifs[0].result_ch, ifs[0].err_timeout,
           ifs[0].dac_start, ifs[0].dac_data, ifs[0].dac_ch, ifs[0].adc_den, ifs[0].adc_daddr,
           ifs[0].state_out};
    checks++;
    if (obs !== 47'h0) begin fails++; $display("FAIL reset_outs0 got %h required 0", obs); end
    obs = {ifs[1].busy, ifs[1].result_valid, ifs[1].result, ifs[1].result_ch, ifs[1].err_timeout,
           ifs[1].dac_start, ifs[1].dac_data, ifs[1].dac_ch, ifs[1].adc_den, ifs[1].adc_daddr,
           ifs[1].state_out};
    checks++;
    if (obs !== 47'h0) begin fails++; $display("FAIL reset_outs2 got %h required 0", obs); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ifs[1].state_out !== 3'd0) begin
      fails++; $display("FAIL reset_idle got %0d required 0", ifs[1].state_out);
    end
  endtask

  task automatic test_single;
    int t0, ds, rv;
    eoc_on[0] = 1'b1; busy_len[0] = 1;
    adc_q[0].push_back(16'hABC0);
    sb[0].push_back('{ch: 2'd2, val: 12'hABC});
    ds = ds_cnt[0]; rv = rv_cnt[0];
    go0(2'd2, 16'h8000, 16'd8, t0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!ifs[0].busy) break;
    end
    checks++;
    if (ifs[0].busy !== 1'b0) begin fails++; $display("FAIL single_done busy=%b required 0", ifs[0].busy); end
    checks++;
    if (ds_cnt[0] - ds != 1) begin fails++; $display("FAIL single_dac_start got %0d required 1", ds_cnt[0] - ds); end
    checks++;
    if (last_dac_data[0] !== 16'h8000) begin
      fails++; $display("FAIL single_dac_data got %h required 8000", last_dac_data[0]);
    end
    checks++;
    if (last_dac_ch[0] !== 2'd2) begin fails++; $display("FAIL single_dac_ch got %0d required 2", last_dac_ch[0]); end
    checks++;
    if (last_daddr[0] !== 7'h12) begin fails++; $display("FAIL single_daddr got %h required 12", last_daddr[0]); end
    checks++;
    if (rv_cnt[0] - rv != 1) begin fails++; $display("FAIL single_rv_count got %0d required 1", rv_cnt[0] - rv); end
    checks++;
    if (rv_cyc[0] - t0 != 16) begin fails++; $display("FAIL single_latency got %0d required 16", rv_cyc[0] - t0); end
  endtask

  task automatic test_average;
    int t0, dn, rv;
    eoc_on[1] = 1'b1; busy_len[1] = 6;
    adc_q[1].push_back(16'h1000); adc_q[1].push_back(16'h1010);
    adc_q[1].push_back(16'h1020); adc_q[1].push_back(16'h1040);
    sb[1].push_back('{ch: 2'd3, val: 12'h101});
    dn = den_cnt[1]; rv = rv_cnt[1];
    go2(2'd3, 16'h1234, 16'd3, t0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!ifs[1].busy) break;
    end
    checks++;
    if (den_cnt[1] - dn != 4) begin fails++; $display("FAIL avg_den_count got %0d required 4", den_cnt[1] - dn); end
    checks++;
    if (rv_cnt[1] - rv != 1) begin fails++; $display("FAIL avg_rv_count got %0d required 1", rv_cnt[1] - rv); end
    checks++;
    if (last_daddr[1] !== 7'h13) begin fails++; $display("FAIL avg_daddr got %h required 13", last_daddr[1]); end
  endtask

  task automatic test_settle;
    int t0, sl, se, fd;
    eoc_on[1] = 1'b1; busy_len[1] = 1;
    repeat (4) adc_q[1].push_back(16'hFFF0);
    sb[1].push_back('{ch: 2'd1, val: 12'hFFF});
    sl = 0; se = -1; fd = -1;
    go2(2'd1, 16'h0001, 16'd20, t0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ifs[1].state_out == 3'd3) begin
        if (se < 0) se = cyc;
        sl++;
      end
      if (ifs[1].adc_den && fd < 0) fd = cyc;
      if (!ifs[1].busy) break;
    end
    checks++;
    if (sl != 21) begin fails++; $display("FAIL settle20_len got %0d required 21", sl); end
    checks++;
    if (se < 0 || fd - se < 21) begin fails++; $display("FAIL settle20_first_den got %0d required >=21", fd - se); end
    repeat (4) adc_q[1].push_back(16'h0550);
    sb[1].push_back('{ch: 2'd2, val: 12'h055});
    sl = 0;
    go2(2'd2, 16'h0002, 16'd0, t0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ifs[1].state_out == 3'd3) sl++;
      if (!ifs[1].busy) break;
    end
    checks++;
    if (sl != 1) begin fails++; $display("FAIL settle0_len got %0d required 1", sl); end
    checks++;
    if (rv_cyc[1] - t0 != 17) begin fails++; $display("FAIL settle0_latency got %0d required 17", rv_cyc[1] - t0); end
  endtask

  task automatic test_start_busy;
    int t0, ds, rv;
    repeat (4) adc_q[1].push_back(16'h2000);
    sb[1].push_back('{ch: 2'd0, val: 12'h200});
    ds = ds_cnt[1]; rv = rv_cnt[1];
    go2(2'd0, 16'h00AA, 16'd5, t0);
    repeat (6) @(negedge clk);
    ifs[1].start = 1'b1; ifs[1].ch_sel = 2'd1; ifs[1].data_in = 16'hFFFF;
    @(negedge clk);
    ifs[1].start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!ifs[1].busy) break;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rv_cnt[1] - rv != 1) begin fails++; $display("FAIL busy_rv_count got %0d required 1", rv_cnt[1] - rv); end
    checks++;
    if (ds_cnt[1] - ds != 1) begin fails++; $display("FAIL busy_dac_start got %0d required 1", ds_cnt[1] - ds); end
    checks++;
    if (ifs[1].result_ch !== 2'd0) begin fails++; $display("FAIL busy_result_ch got %0d required 0", ifs[1].result_ch); end
  endtask

  task automatic test_timeout;
    int t0, we, ec, er, rv;
    eoc_on[1] = 1'b0;
    we = -1; ec = -1; er = err_cnt[1]; rv = rv_cnt[1];
    go2(2'd2, 16'h0100, 16'd2, t0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ifs[1].state_out == 3'd4 && we < 0) we = cyc;
      if (ifs[1].err_timeout) ec = cyc;
      if (!ifs[1].busy) break;
    end
    checks++;
    if (we < 0 || ec - we != TO) begin fails++; $display("FAIL timeout_delay got %0d required %0d", ec - we, TO); end
    @(negedge clk);
    checks++;
    if (err_cnt[1] - er != 1) begin fails++; $display("FAIL timeout_err_count got %0d required 1", err_cnt[1] - er); end
    checks++;
    if (rv_cnt[1] - rv != 0) begin fails++; $display("FAIL timeout_rv_count got %0d required 0", rv_cnt[1] - rv); end
    checks++;
    if (ifs[1].busy !== 1'b0) begin fails++; $display("FAIL timeout_busy got %b required 0", ifs[1].busy); end
    checks++;
    if ({ifs[1].result_ch, ifs[1].result} !== {2'd0, 12'h200}) begin
      fails++; $display("FAIL timeout_result_held got ch=%0d res=%h required ch=0 res=200",
                        ifs[1].result_ch, ifs[1].result);
    end
    eoc_on[1] = 1'b1;
    adc_q[1].push_back(16'h0010); adc_q[1].push_back(16'h0020);
    adc_q[1].push_back(16'h0030); adc_q[1].push_back(16'h0040);
    sb[1].push_back('{ch: 2'd2, val: 12'h002});
    rv = rv_cnt[1];
    go2(2'd2, 16'h0100, 16'd0, t0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!ifs[1].busy) break;
    end
    checks++;
    if (rv_cnt[1] - rv != 1) begin fails++; $display("FAIL timeout_recover got %0d required 1", rv_cnt[1] - rv); end
  endtask

  task automatic test_reset_midop;
    int t0, er, rv;
    logic [46:0] obs;
    hold_drdy[1] = 1'b1;
    er = err_cnt[1]; rv = rv_cnt[1];
    go2(2'd1, 16'h0F0F, 16'd1, t0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifs[1].state_out == 3'd6) break;
    end
    checks++;
    if (ifs[1].state_out !== 3'd6) begin fails++; $display("FAIL rstmid_reach got %0d required 6", ifs[1].state_out); end
    rst = 1'b1;
    #1;
    obs = {ifs[1].busy, ifs[1].result_valid, ifs[1].result, ifs[1].result_ch, ifs[1].err_timeout,
           ifs[1].dac_start, ifs[1].dac_data, ifs[1].dac_ch, ifs[1].adc_den, ifs[1].adc_daddr,
           ifs[1].state_out};
    checks++;
    if (obs !== 47'h0) begin fails++; $display("FAIL rstmid_outs got %h required 0", obs); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_drdy[1] = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (rv_cnt[1] - rv != 0 || err_cnt[1] - er != 0) begin
      fails++; $display("FAIL rstmid_quiet got rv=%0d err=%0d required 0 0", rv_cnt[1] - rv, err_cnt[1] - er);
    end
    checks++;
    if (ifs[1].state_out !== 3'd0) begin fails++; $display("FAIL rstmid_state got %0d required 0", ifs[1].state_out); end
  endtask

  initial begin
    ifs[0].start = 1'b0; ifs[0].ch_sel = '0; ifs[0].data_in = '0; ifs[0].settle_cycles = '0;
    ifs[1].start = 1'b0; ifs[1].ch_sel = '0; ifs[1].data_in = '0; ifs[1].settle_cycles = '0;
    test_reset();
    test_single();
    test_average();
    test_settle();
    test_start_busy();
    test_timeout();
    test_reset_midop();
    checks++;
    if (sb[0].size() != 0 || sb[1].size() != 0) begin
      fails++; $display("FAIL sb_drain got %0d/%0d pending required 0/0", sb[0].size(), sb[1].size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
